position_stack: RTL and testbench
=================================

Name: position_stack

Overview:
- LIFO of queen positions that serves the 8-queen stacked controller, which issues push/pop pulses and waits on stack_ready.
- Each entry is a packed {row, column}. A push saves the placed queen; a pop restores the previous queen for backtracking.
- In drain mode (enable_output high), each popped entry also goes to the result output stream until the stack underflows.
- Sits beside the position registers in the 8-queen datapath.

Parameters:
- DEPTH, 8, number of entries (one per board row).
- COORD_W, 3, width of the row and column fields.
- ENTRY_W, 2*COORD_W, packed entry width: row in [ENTRY_W-1:COORD_W], column in [COORD_W-1:0].

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  reset, asynchronous, active-low.
- clear  in  1  synchronous flush: empties the stack and clears the sticky flags.
- push  in  1  push request, sampled only while stack_ready=1.
- pop  in  1  pop request, sampled only while stack_ready=1.
- enable_output  in  1  drain mode: each popped entry is also emitted on out_data.
- data_in  in  ENTRY_W  entry to push.
- stack_ready  out  1  high = idle and able to accept a request.
- popped_data  out  ENTRY_W  registered last popped entry; held until the next successful pop.
- top_data  out  ENTRY_W  current top entry (combinational); 0 when empty.
- out_valid  out  1  one-cycle strobe: out_data is a drained result.
- out_data  out  ENTRY_W  drained entry.
- count  out  $clog2(DEPTH+1)  current occupancy.
- empty  out  1  count==0.
- full  out  1  count==DEPTH.
- underflow  out  1  sticky: a pop was made on an empty stack.
- overflow  out  1  sticky: a push was made on a full stack.

Behaviour:
- Reset (async, reset_n=0):
  - state=READY, sp=0, stack_ready=1.
  - popped_data=0, out_data=0, out_valid=0, underflow=0, overflow=0.
  - Memory contents are don't-care.
  - Reset mid-operation aborts the operation; no partial write is visible.
- FSM states: READY, WRITE, READ.
- Accept: in READY with push=1 or pop=1.
  - If both are high, push wins and the pop is dropped silently.
  - Requests while stack_ready=0 are ignored, not queued.
- Push accepted at cycle T:
  - data_in is latched at T.
  - T+1, state WRITE, stack_ready=0: if not full, mem[sp]<=latched and sp<=sp+1; if full, write dropped and overflow<=1.
  - A successful push clears underflow.
  - T+2: READY, stack_ready=1.
- Pop accepted at cycle T:
  - T+1, state READ, stack_ready=0.
  - If not empty: popped_data<=mem[sp-1] and sp<=sp-1. If enable_output was high at T, then out_data<=mem[sp-1] and out_valid=1 at T+2 for exactly one cycle.
  - If empty: sp unchanged, popped_data unchanged, no out_valid, underflow<=1.
  - T+2: READY.
- Throughput: the minimum handshake cycle is 2 clocks per operation. A requester holding pop high drains one entry every 2 cycles.
- The controller waiting on stack_ready one cycle after its pulse always sees 0 first, so its wait state is never skipped.
- Sticky flags:
  - underflow stays high until a successful push or clear.
  - overflow stays high until clear.
- clear:
  - In any state, forces READY and sp=0, clears underflow, overflow and out_valid.
  - Clear has priority over a simultaneous request.
- Flags: count, empty and full are derived combinationally from sp.
- Width rules: sp ranges 0..DEPTH and never wraps. top_data indexes sp-1 only when sp>0.

Decomposition:
- Shared package queen_pkg holds:
  - COORD_W and ENTRY_W;
  - field helpers for packing and unpacking {row, col};
  - the stack state encodings READY=2'd0, WRITE=2'd1, READ=2'd2.
- One sub-module, stack_regfile: a DEPTH x ENTRY_W register array.
  - Synchronous write port (we, waddr, wdata).
  - Two combinational read ports, one for top and one for pop.
  - No reset on the array.

Test Plan:
- Push 6'o12, 6'o25, 6'o31 (each push pulse followed by waiting for stack_ready) -> count=3, top_data=6'o31. stack_ready is low exactly 1 cycle after each pulse.
- Pop twice from that state -> popped_data=6'o31 then 6'o25; count=1; out_valid stays 0 (enable_output=0).
- Fill to 8 entries, push 6'o77 -> overflow=1, count=8, top_data unchanged; then clear -> count=0, overflow=0.
- enable_output=1 with pop held high on 3 entries -> out_valid pulses carry 6'o31, 6'o25, 6'o12 at 2-cycle spacing. The 4th pop sets underflow=1 with no out_valid; underflow stays high while pop remains asserted.
- push=1 and pop=1 in the same READY cycle with count=2 -> count=3, popped_data unchanged.
- Assert reset_n=0 in the WRITE cycle of a push on an empty stack -> immediately stack_ready=1 and count=0; after release, underflow=0 and overflow=0.

Source files
------------

// File: rtl/queen_pkg.sv
// Shared types and helpers for the 8-queen datapath: coordinate widths,
// {row, col} entry packing, and the position-stack state encoding.
package queen_pkg;

    localparam int COORD_W = 3;
    localparam int ENTRY_W = 2 * COORD_W;

    typedef logic [COORD_W-1:0] coord_t;
    typedef logic [ENTRY_W-1:0] entry_t;

    typedef enum logic [1:0] {
        READY = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } stack_state_e;

    function automatic entry_t pack_entry(input coord_t row, input coord_t col);
        return {row, col};
    endfunction

    function automatic coord_t entry_row(input entry_t e);
        return e[ENTRY_W-1:COORD_W];
    endfunction

    function automatic coord_t entry_col(input entry_t e);
        return e[COORD_W-1:0];
    endfunction

endpackage

// File: rtl/stack_regfile.sv
// DEPTH x ENTRY_W register array with one synchronous write port and two
// combinational read ports. The array itself is not reset.
module stack_regfile #(
    parameter int DEPTH   = 8,
    parameter int ENTRY_W = 6,
    parameter int ADDR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic               clk,
    input  logic               we,
    input  logic [ADDR_W-1:0]  waddr,
    input  logic [ENTRY_W-1:0] wdata,
    input  logic [ADDR_W-1:0]  top_raddr,
    output logic [ENTRY_W-1:0] top_rdata,
    input  logic [ADDR_W-1:0]  pop_raddr,
    output logic [ENTRY_W-1:0] pop_rdata
);

    logic [ENTRY_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign top_rdata = mem_q[top_raddr];
    assign pop_rdata = mem_q[pop_raddr];

endmodule

// File: rtl/position_stack.sv
// LIFO of packed {row, col} queen positions with a two-cycle push/pop
// handshake, optional drain-to-output on pop, and sticky error flags.
module position_stack #(
    parameter int DEPTH   = 8,
    parameter int COORD_W = queen_pkg::COORD_W,
    parameter int ENTRY_W = 2 * COORD_W
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       clear,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       enable_output,
    input  logic [ENTRY_W-1:0]         data_in,
    output logic                       stack_ready,
    output logic [ENTRY_W-1:0]         popped_data,
    output logic [ENTRY_W-1:0]         top_data,
    output logic                       out_valid,
    output logic [ENTRY_W-1:0]         out_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full,
    output logic                       underflow,
    output logic                       overflow
);

    import queen_pkg::*;

    localparam int SP_W   = $clog2(DEPTH + 1);
    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    stack_state_e state_q, state_d;

    logic [SP_W-1:0]    sp_q, sp_d;
    logic [ENTRY_W-1:0] latch_q, latch_d;
    logic               drain_q, drain_d;
    logic [ENTRY_W-1:0] popped_q, popped_d;
    logic [ENTRY_W-1:0] out_data_q, out_data_d;
    logic               out_valid_q, out_valid_d;
    logic               underflow_q, underflow_d;
    logic               overflow_q, overflow_d;

    logic               we;
    logic [ADDR_W-1:0]  waddr;
    logic [ADDR_W-1:0]  top_addr;
    logic [ENTRY_W-1:0] top_rdata;
    logic [ENTRY_W-1:0] pop_rdata;
    logic               is_empty;
    logic               is_full;

    assign is_empty = (sp_q == '0);
    assign is_full  = (sp_q == SP_W'(DEPTH));
    assign waddr    = ADDR_W'(sp_q);
    assign top_addr = ADDR_W'(sp_q - SP_W'(1));

    stack_regfile #(
        .DEPTH   (DEPTH),
        .ENTRY_W (ENTRY_W),
        .ADDR_W  (ADDR_W)
    ) u_regfile (
        .clk       (clk),
        .we        (we),
        .waddr     (waddr),
        .wdata     (latch_q),
        .top_raddr (top_addr),
        .top_rdata (top_rdata),
        .pop_raddr (top_addr),
        .pop_rdata (pop_rdata)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= READY;
        end else begin
            state_q <= state_d;
        end
    end

    // Push wins over a simultaneous pop; clear overrides any request.
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = READY;
        end else begin
            case (state_q)
                READY: begin
                    if (push) begin
                        state_d = WRITE;
                    end else if (pop) begin
                        state_d = READ;
                    end
                end
                WRITE:   state_d = READY;
                READ:    state_d = READY;
                default: state_d = READY;
            endcase
        end
    end

    always_comb begin
        stack_ready = (state_q == READY);
    end

    always_comb begin
        sp_d        = sp_q;
        latch_d     = latch_q;
        drain_d     = drain_q;
        popped_d    = popped_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        underflow_d = underflow_q;
        overflow_d  = overflow_q;
        we          = 1'b0;
        if (clear) begin
            sp_d        = '0;
            underflow_d = 1'b0;
            overflow_d  = 1'b0;
        end else begin
            case (state_q)
                READY: begin
                    if (push) begin
                        latch_d = data_in;
                    end else if (pop) begin
                        drain_d = enable_output;
                    end
                end
                WRITE: begin
                    if (!is_full) begin
                        we          = 1'b1;
                        sp_d        = sp_q + SP_W'(1);
                        underflow_d = 1'b0;
                    end else begin
                        overflow_d = 1'b1;
                    end
                end
                READ: begin
                    if (!is_empty) begin
                        popped_d = pop_rdata;
                        sp_d     = sp_q - SP_W'(1);
                        if (drain_q) begin
                            out_data_d  = pop_rdata;
                            out_valid_d = 1'b1;
                        end
                    end else begin
                        underflow_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sp_q        <= '0;
            latch_q     <= '0;
            drain_q     <= 1'b0;
            popped_q    <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            underflow_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            sp_q        <= sp_d;
            latch_q     <= latch_d;
            drain_q     <= drain_d;
            popped_q    <= popped_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            underflow_q <= underflow_d;
            overflow_q  <= overflow_d;
        end
    end

    assign popped_data = popped_q;
    assign top_data    = is_empty ? '0 : top_rdata;
    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign count       = sp_q;
    assign empty       = is_empty;
    assign full        = is_full;
    assign underflow   = underflow_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_position_stack.sv
// Directed bench for position_stack: push/pop handshake, overflow, drain,
// push/pop collision and reset during a write.
module tb_position_stack;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       clear;
    logic       push;
    logic       pop;
    logic       enable_output;
    logic [5:0] data_in;
    logic       stack_ready;
    logic [5:0] popped_data;
    logic [5:0] top_data;
    logic       out_valid;
    logic [5:0] out_data;
    logic [3:0] count;
    logic       empty;
    logic       full;
    logic       underflow;
    logic       overflow;

    int checks = 0;
    int errors = 0;
    logic       lastOutValid;
    logic [5:0] lastOutData;

    position_stack dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .clear         (clear),
        .push          (push),
        .pop           (pop),
        .enable_output (enable_output),
        .data_in       (data_in),
        .stack_ready   (stack_ready),
        .popped_data   (popped_data),
        .top_data      (top_data),
        .out_valid     (out_valid),
        .out_data      (out_data),
        .count         (count),
        .empty         (empty),
        .full          (full),
        .underflow     (underflow),
        .overflow      (overflow)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Waits a bounded number of cycles for stack_ready and checks it came back.
    task automatic waitReady();
        int n = 0;
        while (stack_ready !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        checkOutput("ready_return", 32'(stack_ready), 1);
    endtask

    // One request pulse from a negedge; optionally checks the busy cycle.
    task automatic applyStimulus(input logic p, input logic q, input logic en,
                                 input logic [5:0] d, input logic checkBusy);
        push = p;
        pop = q;
        enable_output = en;
        data_in = d;
        @(negedge clk);
        push = 1'b0;
        pop = 1'b0;
        if (checkBusy) checkOutput("busy_after_pulse", 32'(stack_ready), 0);
        waitReady();
        lastOutValid = out_valid;
        lastOutData = out_data;
    endtask

    task automatic doClear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        reset_n = 1'b0;
        clear = 1'b0;
        push = 1'b0;
        pop = 1'b0;
        enable_output = 1'b0;
        data_in = '0;
        repeat (2) @(negedge clk);

        checkOutput("rst_ready", 32'(stack_ready), 1);
        checkOutput("rst_count", 32'(count), 0);
        checkOutput("rst_empty", 32'(empty), 1);
        checkOutput("rst_full", 32'(full), 0);
        checkOutput("rst_popped", 32'(popped_data), 0);
        checkOutput("rst_top", 32'(top_data), 0);
        checkOutput("rst_out_valid", 32'(out_valid), 0);
        checkOutput("rst_out_data", 32'(out_data), 0);
        checkOutput("rst_underflow", 32'(underflow), 0);
        checkOutput("rst_overflow", 32'(overflow), 0);
        reset_n = 1'b1;
        @(negedge clk);

        applyStimulus(1, 0, 0, 6'o12, 1);
        applyStimulus(1, 0, 0, 6'o25, 1);
        applyStimulus(1, 0, 0, 6'o31, 1);
        checkOutput("push3_count", 32'(count), 3);
        checkOutput("push3_top", 32'(top_data), 'o31);

        applyStimulus(0, 1, 0, 6'o00, 1);
        checkOutput("pop1_data", 32'(popped_data), 'o31);
        checkOutput("pop1_no_out", 32'(lastOutValid), 0);
        applyStimulus(0, 1, 0, 6'o00, 1);
        checkOutput("pop2_data", 32'(popped_data), 'o25);
        checkOutput("pop2_count", 32'(count), 1);
        checkOutput("pop2_no_out", 32'(lastOutValid), 0);

        for (int i = 0; i < 7; i++) applyStimulus(1, 0, 0, 6'(8'o40 + i), 0);
        checkOutput("fill_count", 32'(count), 8);
        checkOutput("fill_full", 32'(full), 1);
        checkOutput("fill_no_ovf", 32'(overflow), 0);
        applyStimulus(1, 0, 0, 6'o77, 1);
        checkOutput("ovf_flag", 32'(overflow), 1);
        checkOutput("ovf_count", 32'(count), 8);
        checkOutput("ovf_top", 32'(top_data), 'o46);
        doClear();
        checkOutput("clr_count", 32'(count), 0);
        checkOutput("clr_overflow", 32'(overflow), 0);
        checkOutput("clr_top", 32'(top_data), 0);

        applyStimulus(1, 0, 0, 6'o12, 0);
        applyStimulus(1, 0, 0, 6'o25, 0);
        applyStimulus(1, 0, 0, 6'o31, 0);
        pop = 1'b1;
        enable_output = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            checkOutput($sformatf("drain_valid_%0d", k), 32'(out_valid),
                        32'((k == 2) || (k == 4) || (k == 6)));
            if (k == 2) checkOutput("drain_data_1", 32'(out_data), 'o31);
            if (k == 4) checkOutput("drain_data_2", 32'(out_data), 'o25);
            if (k == 6) checkOutput("drain_data_3", 32'(out_data), 'o12);
            if (k == 7) checkOutput("drain_pre_unf", 32'(underflow), 0);
            if (k == 8) checkOutput("drain_unf", 32'(underflow), 1);
            if (k == 10) checkOutput("drain_unf_held", 32'(underflow), 1);
        end
        pop = 1'b0;
        enable_output = 1'b0;
        waitReady();
        checkOutput("drain_count", 32'(count), 0);

        applyStimulus(1, 0, 0, 6'o12, 0);
        checkOutput("push_clears_unf", 32'(underflow), 0);
        applyStimulus(1, 0, 0, 6'o25, 0);
        applyStimulus(1, 1, 0, 6'o53, 1);
        checkOutput("both_count", 32'(count), 3);
        checkOutput("both_popped", 32'(popped_data), 'o12);
        checkOutput("both_top", 32'(top_data), 'o53);

        doClear();
        push = 1'b1;
        data_in = 6'o17;
        @(negedge clk);
        push = 1'b0;
        checkOutput("wr_state_busy", 32'(stack_ready), 0);
        reset_n = 1'b0;
        #1;
        checkOutput("rst_mid_ready", 32'(stack_ready), 1);
        checkOutput("rst_mid_count", 32'(count), 0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("rel_count", 32'(count), 0);
        checkOutput("rel_ready", 32'(stack_ready), 1);
        checkOutput("rel_underflow", 32'(underflow), 0);
        checkOutput("rel_overflow", 32'(overflow), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
